// File: rtl/mips_rf_pkg.sv
// Shared types for the multi-port MIPS register file: write-path shift modes
// and the clear-engine states.
package mips_rf_pkg;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRL  = 2'b10,
        SH_SRA  = 2'b11
    } shift_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/rf_shifter.sv
// Write-path data selector: passes wd through or shifts the register-file
// source operand left, logically right, or arithmetically right.
module rf_shifter
    import mips_rf_pkg::*;
#(
    parameter  int W  = 32,
    localparam int SW = $clog2(W)
) (
    input  logic [W-1:0]  wd,
    input  logic [W-1:0]  src,
    input  logic [SW-1:0] shamt,
    input  shift_e        shift,
    output logic [W-1:0]  result
);

    // Select the value to be written for the current shift mode
    always_comb begin
        result = wd;
        case (shift)
            SH_NONE: result = wd;
            SH_SLL:  result = src << shamt;
            SH_SRL:  result = src >> shamt;
            SH_SRA:  result = $signed(src) >>> shamt;
            default: result = wd;
        endcase
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Parametrised multi-read-port register file with post-reset clear engine.
// Optional same-cycle write-to-read forwarding is enabled by RF_BYPASS_EN.
module mips_regfile_mp
    import mips_rf_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int DEPTH = 32,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int SW    = $clog2(W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [W-1:0]        wd,
    input  logic [1:0]          shift,
    input  logic [SW-1:0]       shamt,
    input  logic [NREAD*AW-1:0] ra,
    output logic [NREAD*W-1:0]  rd,
    output logic                ready,
    output logic                busy
);

    state_e         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   rf_q [DEPTH];
    logic [AW-1:0]  src_addr_s;
    logic [W-1:0]   src_s;
    logic [W-1:0]   wr_data_s;
    logic           wr_act_s;

    assign ready = (state_q == READY);
    assign busy  = (state_q != READY);

    // The shift source always comes from the array, never from the bypass path
    assign src_addr_s = ra[AW +: AW];
    assign src_s      = (src_addr_s != '0) ? rf_q[src_addr_s] : {W{1'b0}};
    assign wr_act_s   = (state_q == READY) && we && (wa != '0);

    rf_shifter #(.W(W)) u_shifter (
        .wd     (wd),
        .src    (src_s),
        .shamt  (shamt),
        .shift  (shift_e'(shift)),
        .result (wr_data_s)
    );

    // Clear-engine state and entry counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk every entry once, then stay usable until reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end else begin
                    state_d = CLEAR;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // Array update: zero fill while clearing, normal writes once ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                rf_q[cnt_q] <= '0;
            end else if (wr_act_s) begin
                rf_q[wa] <= wr_data_s;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] raddr_s;
        logic [W-1:0]  rdata_s;

        assign raddr_s = ra[i*AW +: AW];

        // Read port: address 0 and the not-yet-cleared array are masked to 0
        always_comb begin
            rdata_s = {W{1'b0}};
            if (ready && (raddr_s != '0)) begin
`ifdef RF_BYPASS_EN
                if (wr_act_s && (raddr_s == wa)) begin
                    rdata_s = wr_data_s;
                end else begin
                    rdata_s = rf_q[raddr_s];
                end
`else
                rdata_s = rf_q[raddr_s];
`endif
            end else begin
                rdata_s = {W{1'b0}};
            end
        end

        assign rd[i*W +: W] = rdata_s;
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Self-checking bench: behavioural model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mips_regfile_mp;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 3;
    localparam int AW    = 5;
    localparam int SW    = 5;

    logic                clk;
    logic                reset;
    logic                we;
    logic [AW-1:0]       wa;
    logic [W-1:0]        wd;
    logic [1:0]          shift;
    logic [SW-1:0]       shamt;
    logic [NREAD*AW-1:0] ra;
    logic [NREAD*W-1:0]  rd;
    logic                ready;
    logic                busy;

    // small configuration: W=16, DEPTH=8, NREAD=4
    logic        reset2;
    logic        we2;
    logic [2:0]  wa2;
    logic [15:0] wd2;
    logic [1:0]  shift2;
    logic [3:0]  shamt2;
    logic [11:0] ra2;
    logic [63:0] rd2;
    logic        ready2;
    logic        busy2;

    int checks;
    int errors;

    // behavioural model
    logic [W-1:0] m_rf [DEPTH];
    int           m_edges;
    logic         m_ready;

    mips_regfile_mp #(.W(W), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .shift(shift),
        .shamt(shamt), .ra(ra), .rd(rd), .ready(ready), .busy(busy)
    );

    mips_regfile_mp #(.W(16), .DEPTH(8), .NREAD(4)) dut2 (
        .clk(clk), .reset(reset2), .we(we2), .wa(wa2), .wd(wd2), .shift(shift2),
        .shamt(shamt2), .ra(ra2), .rd(rd2), .ready(ready2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mshift(input logic [1:0] m, input logic [W-1:0] wdat,
                                            input logic [W-1:0] s, input int n);
        logic [W-1:0] r;
        case (m)
            2'd0: r = wdat;
            2'd1: r = s << n;
            2'd2: r = s >> n;
            default: begin
                r = s >> n;
                if (s[W-1]) begin
                    for (int k = 0; k < n; k++) r[W-1-k] = 1'b1;
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] m_wval();
        logic [AW-1:0] a1;
        logic [W-1:0]  s;
        a1 = ra[AW +: AW];
        s  = (a1 != 0) ? m_rf[a1] : 32'h0;
        return mshift(shift, wd, s, int'(shamt));
    endfunction

    function automatic logic [W-1:0] exp_rd(input int i);
        logic [AW-1:0] a;
        a = ra[i*AW +: AW];
        if (!m_ready || a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (we && wa != 0 && a == wa) return m_wval();
`endif
        return m_rf[a];
    endfunction

    // one clock: compare at negedge, advance model at posedge
    task automatic step();
        logic [W-1:0] v;
        @(negedge clk);
        for (int i = 0; i < NREAD; i++) begin
            chk($sformatf("rd%0d", i), rd[i*W +: W], exp_rd(i));
        end
        chk("ready", {31'd0, ready}, {31'd0, m_ready});
        chk("busy", {31'd0, busy}, {31'd0, !m_ready});
        @(posedge clk);
        if (reset) begin
            m_edges = 0;
            m_ready = 1'b0;
        end else if (!m_ready) begin
            m_edges++;
            if (m_edges == DEPTH) begin
                for (int k = 0; k < DEPTH; k++) m_rf[k] = 32'h0;
                m_ready = 1'b1;
            end
        end else if (we && wa != 0) begin
            v = m_wval();
            m_rf[wa] = v;
        end
        #1;
    endtask

    task automatic set_ra(input int p0, input int p1, input int p2);
        ra = {AW'(p2), AW'(p1), AW'(p0)};
    endtask

    task automatic wr(input int a, input logic [W-1:0] d, input logic [1:0] m, input int n);
        we = 1'b1; wa = AW'(a); wd = d; shift = m; shamt = SW'(n);
        step();
        we = 1'b0; shift = 2'd0; shamt = 5'd0;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_edges = 0; m_ready = 1'b0;
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; shift = 2'd0; shamt = '0; ra = '0;
        reset2 = 1'b1; we2 = 1'b0; wa2 = 3'd0; wd2 = 16'h0; shift2 = 2'd0; shamt2 = 4'd0; ra2 = 12'h0;

        step(); step();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd1);

        // clear: we ignored, every read port zero, ready after exactly DEPTH edges
        reset = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'hFF;
        for (int k = 1; k <= DEPTH; k++) begin
            ra = NREAD*AW'($urandom);
            step();
            if (k == DEPTH - 1) chk("clear_ready_31", {31'd0, ready}, 32'd0);
            if (k == DEPTH)     chk("clear_ready_32", {31'd0, ready}, 32'd1);
        end
        we = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            set_ra(a, a, (a + 1) % DEPTH);
            step();
        end
        set_ra(4, 4, 4); #1;
        chk("clear_we_ignored", rd[0 +: W], 32'h0);

        // write and fan-out
        set_ra(0, 0, 0);
        wr(5, 32'hDEADBEEF, 2'd0, 0);
        set_ra(5, 5, 0); #1;
        chk("fan_rd0", rd[0 +: W], 32'hDEADBEEF);
        chk("fan_rd1", rd[W +: W], 32'hDEADBEEF);
        chk("fan_rd2", rd[2*W +: W], 32'h0);
        set_ra(0, 0, 0);
        wr(0, 32'h1234, 2'd0, 0);
        set_ra(0, 0, 0); #1;
        chk("zero_addr", rd[0 +: W], 32'h0);

        // shift modes with src = rf[3]
        set_ra(0, 0, 0);
        wr(3, 32'h80000010, 2'd0, 0);
        set_ra(0, 3, 0);
        wr(7, 32'h0, 2'd1, 4);  set_ra(7, 3, 0); #1; chk("sll4", rd[0 +: W], 32'h00000100);
        set_ra(0, 3, 0);
        wr(7, 32'h0, 2'd2, 4);  set_ra(7, 3, 0); #1; chk("srl4", rd[0 +: W], 32'h08000001);
        set_ra(0, 3, 0);
        wr(7, 32'h0, 2'd3, 4);  set_ra(7, 3, 0); #1; chk("sra4", rd[0 +: W], 32'hF8000001);
        set_ra(0, 3, 0);
        wr(7, 32'h0, 2'd3, 0);  set_ra(7, 3, 0); #1; chk("sra0", rd[0 +: W], 32'h80000010);
        set_ra(0, 3, 0);
        wr(7, 32'h0, 2'd1, 0);  set_ra(7, 3, 0); #1; chk("sll0", rd[0 +: W], 32'h80000010);

        // same-cycle read of the address being written
        set_ra(9, 0, 0);
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; shift = 2'd0; #1;
`ifdef RF_BYPASS_EN
        chk("bypass_same", rd[0 +: W], 32'hA5A5A5A5);
`else
        chk("nobypass_same", rd[0 +: W], 32'h0);
`endif
        step();
        we = 1'b0; #1;
        chk("bypass_after", rd[0 +: W], 32'hA5A5A5A5);

        // reset in the middle of a clear restarts the count
        reset = 1'b1; step();
        reset = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'hFF;
        repeat (10) step();
        reset = 1'b1; step();
        reset = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            if (k == DEPTH - 1) chk("midclr_ready_31", {31'd0, ready}, 32'd0);
            if (k == DEPTH)     chk("midclr_ready_32", {31'd0, ready}, 32'd1);
        end
        we = 1'b0;
        set_ra(4, 5, 9); #1;
        chk("midclr_rf4", rd[0 +: W], 32'h0);
        chk("midclr_rf5", rd[W +: W], 32'h0);
        chk("midclr_rf9", rd[2*W +: W], 32'h0);

        // narrow configuration
        reset2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 7) chk("p_ready_7", {31'd0, ready2}, 32'd0);
            if (k == 8) chk("p_ready_8", {31'd0, ready2}, 32'd1);
        end
        we2 = 1'b1; wa2 = 3'd1; wd2 = 16'h8000; shift2 = 2'd0;
        step();
        ra2 = 12'(1) << 3; wa2 = 3'd2; shift2 = 2'd3; shamt2 = 4'd15;
        step();
        we2 = 1'b0; ra2 = 12'(2) | (12'(1) << 9); #1;
        chk("p_sra15", {16'h0, rd2[15:0]}, 32'h0000FFFF);
        chk("p_rd3", {16'h0, rd2[63:48]}, 32'h00008000);
        chk("p_rd1_zero", {16'h0, rd2[31:16]}, 32'h0);

        // randomized traffic, occasional reset
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 249) == 0);
            we    = $urandom_range(0, 1) == 1;
            wa    = AW'($urandom);
            wd    = $urandom;
            shift = 2'($urandom);
            shamt = SW'($urandom);
            ra    = NREAD*AW'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_regfile_mp.md
Name: mips_regfile_mp

Overview:
Parametrised multi-read-port register file for the MIPS datapath. It generalises the fixed 32x32, 2-read register file in width, depth and read-port count, and keeps the write-path shift modes (write, SLL, SRL, SRA).
- Adds a sequential post-reset clear engine with a ready flag.
- Adds correct signed arithmetic right shift.
- Adds optional same-cycle write bypass.
- Sits in the decode stage and feeds the ALU operand muxes.

Parameters:
W, 32, data width in bits (>=8)
DEPTH, 32, number of registers (power of two, >=4)
NREAD, 2, number of read ports (>=2)
AW, $clog2(DEPTH), register address width (derived; not overridden)
SW, $clog2(W), shift-amount width (derived)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
we  in  1  write enable
wa  in  AW  write address
wd  in  W  write data, used when shift==SH_NONE
shift  in  2  write-path mode: 00 wd, 01 SLL, 10 SRL, 11 SRA
shamt  in  SW  shift amount
ra  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd  out  NREAD*W  read data; port i occupies bits [i*W +: W]
ready  out  1  clear complete; file usable
busy  out  1  clear engine active; equals ~ready

Behaviour:
- FSM states: CLEAR, READY.
- Reset:
  - Any edge with reset=1 sets state=CLEAR and cnt=0, and writes no entry.
  - After reset: ready=0, busy=1.
- CLEAR (reset=0):
  - Each edge writes rf[cnt]<=0 and then cnt<=cnt+1.
  - On the edge that writes entry DEPTH-1, state<=READY.
  - ready rises exactly DEPTH edges after the first edge with reset low.
- During CLEAR:
  - we is ignored (no write occurs).
  - All rd ports output 0.
- Reset asserted mid-clear: state=CLEAR and cnt restarts at 0. No partial resume.
- READY, write (we=1, wa!=0), by shift mode:
  - shift 00: rf[wa]<=wd
  - shift 01: rf[wa]<=src<<shamt
  - shift 10: rf[wa]<=src>>shamt (logical)
  - shift 11: rf[wa]<=$signed(src)>>>shamt (sign fill)
- Shift source src is the stored value at ra port 1 (rf[ra1]), or 0 if ra port 1 == 0. src is never the bypassed value.
- Writes to address 0 are dropped. Address 0 always reads 0 on every port in every state.
- Reads are combinational (asynchronous) from the array. Port i: rd_i = (ra_i!=0 && ready) ? rf[ra_i] : 0.
- Without bypass, a write is visible on rd the cycle after the write edge.
- Multiple ports may read the same address; each gets the identical value.
- shamt uses the full SW bits; shamt=0 returns src unchanged in every shift mode.
- No X may leave rd: the array contents before the clear completes are masked by ready.

Optional Feature:
RF_BYPASS_EN.
- Defined:
  - In READY, a port with we=1, wa!=0 and ra_i==wa outputs the value being written this cycle (shifted result included).
  - Address 0 is never bypassed.
  - No bypass occurs during CLEAR.
- Undefined:
  - No forwarding; rd shows the pre-write value until after the edge.
  - The forwarding logic is not synthesised.

Decomposition:
- Package mips_rf_pkg:
  - typedef enum logic[1:0] shift_e {SH_NONE, SH_SLL, SH_SRL, SH_SRA}
  - typedef enum logic state_e {CLEAR, READY}
- Sub-module rf_shifter (combinational, parameter W). Inputs: src, shamt, shift. Output: result. Contains the SH_NONE passthrough to wd.
- Read ports are built with a generate loop over NREAD. No further sub-modules.

Test Plan:
- Reset then clear (DEPTH=32):
  - Hold reset 2 cycles, release -> ready=0 for exactly 32 edges, then ready=1.
  - Every rd=0 during clear; every register reads 0 after clear.
- Write and port fan-out (NREAD=3):
  - wa=5 wd=0xDEADBEEF, then ra={5,5,0} -> rd={0xDEADBEEF,0xDEADBEEF,0}.
  - Write to wa=0 with 0x1234 -> reads 0.
- Shift modes, with rf[3]=0x80000010 and ra port1=3, wa=7:
  - SLL 4 -> 0x00000100
  - SRL 4 -> 0x08000001
  - SRA 4 -> 0xF8000001
  - shamt=0 -> 0x80000010
- Reset mid-clear:
  - Assert reset at clear cycle 10, release -> ready rises 32 edges after release.
  - we=1 during clear (wa=4, wd=0xFF) -> rf[4] reads 0 after ready.
- Bypass:
  - With RF_BYPASS_EN: write wa=9 wd=0xA5A5A5A5 with ra0=9 in the same cycle -> rd0=0xA5A5A5A5 before the edge.
  - Without RF_BYPASS_EN: same stimulus -> rd0 shows the old value (0), then 0xA5A5A5A5 after the edge.
- Parametrisation: W=16, DEPTH=8, NREAD=4 -> clear takes 8 edges; SRA of 0x8000 by 15 -> 0xFFFF.
